// File: rtl/cordic_angle_sweep.sv
// cordic_angle_sweep: emits a start/step/count sweep of fixed-point angles,
// wrapped into [-PI, +PI], into the CORDIC core's input FIFO.
module cordic_angle_sweep #(
  parameter int          FRAC_BITS = 14,
  parameter logic [31:0] PI_FIXED  = 32'h0000C910,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      start_angle,
  input  logic [31:0]      step,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      out_din,
  output logic             out_wr_en,
  input  logic             out_full
);
  if (PI_FIXED[31] || (PI_FIXED >> FRAC_BITS) != 32'd3) begin : g_bad_pi
    $error("PI_FIXED does not encode pi with FRAC_BITS fractional bits");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        angle_q, angle_d, step_q, step_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic signed [32:0] pi_s, sum;
  logic [31:0]        wrapped;

  assign pi_s = {1'b0, PI_FIXED};

  // 33-bit sum cannot overflow for |step| <= PI; exactly +/-PI stays put
  always_comb begin
    sum     = $signed({angle_q[31], angle_q}) + $signed({step_q[31], step_q});
    wrapped = 32'(sum > pi_s ? sum - (pi_s <<< 1) : sum < -pi_s ? sum + (pi_s <<< 1) : sum);
  end

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    step_d    = step_q;
    remain_d  = remain_q;
    busy      = state_q == RUN;
    done      = state_q == FIN;
    out_wr_en = busy && !out_full;
    out_din   = busy ? angle_q : '0;
    if (state_q == IDLE && start) begin
      angle_d  = start_angle;
      step_d   = step;
      remain_d = count;
      state_d  = count != '0 ? RUN : FIN;
    end else if (out_wr_en) begin
      angle_d  = wrapped;
      remain_d = remain_q - CNT_W'(1);
      state_d  = remain_q == CNT_W'(1) ? FIN : RUN;
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      angle_q  <= '0;
      step_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      step_q   <= step_d;
      remain_q <= remain_d;
    end
  end
endmodule

// File: tb/tb_cordic_angle_sweep.sv
// tb_cordic_angle_sweep: directed sweeps checked against a queue-based
// angle model, plus literal expectations that pin the model.
module tb_cordic_angle_sweep;
  logic        clock = 0, reset = 0, start = 0, out_full = 0;
  logic [31:0] start_angle = 0, step = 0;
  logic [15:0] count = 0;
  logic        busy, done, out_wr_en;
  logic [31:0] out_din;
  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];

  cordic_angle_sweep dut (
    .clock(clock), .reset(reset), .start(start), .start_angle(start_angle),
    .step(step), .count(count), .busy(busy), .done(done), .out_din(out_din),
    .out_wr_en(out_wr_en), .out_full(out_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] mwrap(input logic [31:0] a, input logic [31:0] s);
    longint x;
    x = longint'($signed(a)) + longint'($signed(s));
    if (x > 51472) x -= 102944;
    else if (x < -51472) x += 102944;
    return x[31:0];
  endfunction

  // every accepted write must be the next angle the model predicts
  always @(negedge clock) if (reset) begin
    chk("done_vs_wr", {31'b0, done && out_wr_en}, 32'd0);
    if (out_wr_en) begin
      wr_log.push_back(out_din);
      if (exp_q.size() == 0) chk("unexpected_write", out_din, 32'hxxxxxxxx);
      else chk("write_value", out_din, exp_q.pop_front());
    end else if (busy && out_full) begin
      chk("stall_no_wr", {31'b0, out_wr_en}, 32'd0);
      chk("stall_din", out_din, exp_q.size() != 0 ? exp_q[0] : 32'hxxxxxxxx);
    end
  end

  task automatic sweep(input logic [31:0] sa, input logic [31:0] st, input logic [15:0] cnt,
                       input int stall_after, input int stall_len, input int restart_cyc);
    int writes = 0, busy_n = 0, done_cyc = 0, full_left = 0;
    logic [31:0] a = sa;
    wr_log.delete();
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(a);
      a = mwrap(a, st);
    end
    start = 1; start_angle = sa; step = st; count = cnt;
    @(posedge clock); #1 start = 0;
    for (int c = 1; c <= int'(cnt) + stall_len + 20 && done_cyc == 0; c++) begin
      @(negedge clock);
      if (out_wr_en) writes++;
      if (busy) busy_n++;
      if (done) done_cyc = c;
      if (stall_after > 0 && out_wr_en && writes == stall_after) full_left = stall_len;
      @(posedge clock); #1;
      out_full = full_left > 0;
      if (full_left > 0) full_left--;
      if (c == restart_cyc) begin
        start = 1; start_angle = 32'h7; step = 32'h1; count = 16'd3;
      end else start = 0;
    end
    out_full = 0;
    start = 0;
    chk("writes", writes, cnt);
    chk("busy_cycles", busy_n, int'(cnt) + stall_len);
    chk("done_cycle", done_cyc, int'(cnt) + stall_len + 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #3;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wr", {31'b0, out_wr_en}, 0);
    chk("rst_din", out_din, 0);
    #4 reset = 1;
    @(posedge clock); #1;

    chk("model_plain", mwrap(32'h0, 32'h4000), 32'h00004000);
    chk("model_pos_wrap", mwrap(32'h0000C000, 32'h4000), 32'hFFFF6DE0);
    chk("model_neg_wrap", mwrap(32'hFFFF4000, 32'hFFFFC000), 32'h00009220);
    chk("model_pi_edge", mwrap(32'h0000C000, 32'h910), 32'h0000C910);

    sweep(32'h0, 32'h4000, 16'd4, 0, 0, 0);
    chk("t1_w0", wr_log[0], 32'h0);
    chk("t1_w3", wr_log[3], 32'h0000C000);

    sweep(32'h0000C000, 32'h4000, 16'd2, 0, 0, 0);
    chk("t2_w1", wr_log[1], 32'hFFFF6DE0);

    sweep(32'hFFFF4000, 32'hFFFFC000, 16'd2, 0, 0, 0);
    chk("t3_w1", wr_log[1], 32'h00009220);

    sweep(32'h0, 32'h4000, 16'd4, 2, 3, 0);
    chk("t4_w2", wr_log[2], 32'h00008000);
    chk("t4_w3", wr_log[3], 32'h0000C000);

    sweep(32'h0, 32'h4000, 16'd0, 0, 0, 0);

    sweep(32'h100, 32'h200, 16'd5, 0, 0, 1);
    chk("t6_w4", wr_log[4], 32'h00000900);
    sweep(32'h100, 32'h200, 16'd3, 0, 0, 3);
    @(negedge clock);
    chk("fin_start_ignored", {31'b0, busy}, 0);
    @(posedge clock); #1;

    sweep(32'h0, 32'h0000C910, 16'd5, 0, 0, 0);
    chk("pi_step_w2", wr_log[2], 32'h0);
    sweep(32'h0, 32'hFFFF36F0, 16'd3, 0, 0, 0);
    chk("neg_pi_w1", wr_log[1], 32'hFFFF36F0);
    chk("neg_pi_w2", wr_log[2], 32'h0);

    wr_log.delete();
    start = 1; start_angle = 32'h1000; step = 32'h10; count = 16'd6;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h1000 + 32'(i * 16));
    @(posedge clock); #1 start = 0;
    for (int c = 0; c < 10 && wr_log.size() < 2; c++) @(negedge clock);
    chk("rst_mid_writes", wr_log.size(), 2);
    #1 reset = 0;
    #1;
    chk("rst_mid_wr", {31'b0, out_wr_en}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_din", out_din, 0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_mid_no_done", {31'b0, done}, 0);
    end
    reset = 1;
    @(posedge clock); #1;
    sweep(32'h1000, 32'h10, 16'd3, 0, 0, 0);
    chk("post_rst_w0", wr_log[0], 32'h1000);
    chk("post_rst_w2", wr_log[2], 32'h1020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_angle_sweep.md
Name: cordic_angle_sweep

Overview:
Upstream stimulus stage for the CORDIC sin/cos core. It generates a programmable sweep of signed fixed-point angles (start, step, count) and writes them into the core's 32-bit input FIFO, honouring its full flag. Each step wraps the angle into [-PI, +PI], so sweeps longer than one revolution stay in range. It replaces file-driven angle loading for on-chip self-test and audio oscillator use.

Parameters:
FRAC_BITS, 14, number of fractional bits in the angle format (signed, two's complement, 32-bit).
PI_FIXED, 32'h0000C910, PI in the angle format (round(pi*2^14) = 51472); 2*PI is 2*PI_FIXED = 102944.
CNT_W, 16, width of the sweep-length counter.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request; samples start_angle/step/count when idle
start_angle  in  32  first angle emitted, signed fixed-point, emitted verbatim
step  in  32  signed increment per sample; legal range |step| <= PI_FIXED
count  in  CNT_W  number of angles to emit
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when the sweep completes
out_din  out  32  angle presented to the downstream FIFO
out_wr_en  out  1  write strobe to the downstream FIFO
out_full  in  1  downstream FIFO full

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; angle, step and remaining registers cleared; busy=0, done=0, out_wr_en=0, out_din=0.
- States: IDLE, RUN, FIN.
- IDLE: on start=1, latch angle<=start_angle, step, and remain<=count. If count!=0, go to RUN; else go to FIN with no writes.
- RUN: out_din=angle register; out_wr_en = !out_full (combinational from the state and out_full).
- RUN, cycle with out_wr_en=1 (write accepted): angle<=wrap(angle+step), remain<=remain-1. When remain==1, go to FIN.
- RUN, cycle with out_full=1: hold all state; no write issued; out_din stable.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RUN only. done is registered and never overlaps out_wr_en.
- Latency: start sampled at edge N; first write strobe is valid during cycle N+1. With no backpressure, throughput is one angle per clock. done is high in the cycle after the final accepted write.
- wrap(): compute s = angle + step at 33 bits.
  - If s > PI_FIXED, result = s - 2*PI_FIXED.
  - Else if s < -PI_FIXED, result = s + 2*PI_FIXED.
  - Else result = s.
  - Truncate to 32 bits. Exactly +/-PI_FIXED is not wrapped.
- start while busy or in FIN: ignored, with no effect on the sweep in progress.
- start in the same cycle the FIN pulse is high: ignored; it is accepted in the following cycle.
- count = 2^CNT_W-1: full count is emitted; remain does not underflow.
- Reset asserted mid-sweep: immediate return to the reset state. No further writes, no done pulse; the partial sweep is abandoned.

Test Plan:
- start_angle=0, step=0x00004000, count=4, out_full=0 -> writes 0x00000000, 0x00004000, 0x00008000, 0x0000C000 on 4 consecutive cycles starting 1 cycle after start; done pulses 1 cycle after the last write; busy high for exactly 4 cycles.
- start_angle=0x0000C000, step=0x00004000, count=2 -> writes 0x0000C000, then 0xFFFF6DE0 (65536-102944 = -37408); positive wrap verified.
- start_angle=0xFFFF4000 (-49152), step=0xFFFFC000, count=2 -> writes 0xFFFF4000, then 0x00009220 (+37408); negative wrap verified.
- count=4 run with out_full held high for 3 cycles after the 2nd write -> no out_wr_en during the stall, out_din held at 0x00008000; exactly 4 writes total with values unchanged; done is delayed by 3 cycles.
- count=0 -> no out_wr_en at any time; done pulses the cycle after start; busy never asserts.
- Second start pulsed mid-sweep -> ignored, exactly count writes occur. In a separate run, reset driven low after the 2nd write -> out_wr_en/busy drop immediately, no done pulse, and a fresh start after release sweeps correctly from start_angle.
